// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single memory port between instruction fetch (IF) and the
//   load/store unit (LSU). One transaction is in flight at a time. LSU has
//   fixed priority; after MAX_WAIT consecutive LSU grants taken while IF was
//   also waiting, the next contended grant goes to IF.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req_*/if_addr         IF read request (valid/ready)
//   if_resp_valid/if_rdata   IF response strobe and data
//   lsu_req_*/lsu_addr/...   LSU load/store request (valid/ready)
//   lsu_resp_valid/rdata     LSU response strobe (load data or store ack)
//   mem_req_*/mem_addr/...   request to memory, fields registered at grant
//   mem_resp_valid/rdata     memory response
//   busy                     a transaction is in flight
//   owner                    0 = IF, 1 = LSU (current or last transaction)
module mem_port_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0]   mem_wmask_q, mem_wmask_d;

  logic grant_lsu, grant_if;

  // LSU wins unless IF is also waiting and the streak limit has been hit.
  assign grant_lsu = lsu_req_valid && (!if_req_valid || (wait_cnt_q < MAX_W));
  assign grant_if  = if_req_valid && !grant_lsu;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    wait_cnt_d     = wait_cnt_q;
    mem_addr_d     = mem_addr_q;
    mem_wen_d      = mem_wen_q;
    mem_wdata_d    = mem_wdata_q;
    mem_wmask_d    = mem_wmask_q;
    if_req_ready   = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    if_resp_valid  = 1'b0;
    lsu_resp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        // Readies depend only on requester valids and local state, never
        // on mem_req_ready.
        if (grant_lsu) begin
          lsu_req_ready = 1'b1;
          mem_addr_d    = lsu_addr;
          mem_wen_d     = lsu_wen;
          mem_wdata_d   = lsu_wdata;
          mem_wmask_d   = lsu_wmask;
          owner_d       = 1'b1;
          state_d       = REQ;
          if (if_req_valid && (wait_cnt_q < MAX_W))
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else if (grant_if) begin
          if_req_ready = 1'b1;
          mem_addr_d   = if_addr;
          mem_wen_d    = 1'b0;
          mem_wdata_d  = '0;
          mem_wmask_d  = '0;
          owner_d      = 1'b0;
          wait_cnt_d   = 4'd0;
          state_d      = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (mem_resp_valid) begin
          if (owner_q) lsu_resp_valid = 1'b1;
          else         if_resp_valid  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      wait_cnt_q  <= 4'd0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

  // Read data passes straight through; consumers qualify with resp_valid.
  assign if_rdata  = mem_rdata;
  assign lsu_rdata = mem_rdata;

  assign mem_addr  = mem_addr_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic if_req_valid = 1'b0, if_req_ready, if_resp_valid;
  logic [63:0] if_addr = '0, if_rdata;
  logic lsu_req_valid = 1'b0, lsu_req_ready, lsu_wen = 1'b0, lsu_resp_valid;
  logic [63:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
  logic [7:0] lsu_wmask = '0;
  logic mem_req_valid, mem_req_ready = 1'b0, mem_wen, mem_resp_valid = 1'b0;
  logic [63:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [7:0] mem_wmask;
  logic busy, owner;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled one more #1 later, well away from either edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rd_of(input logic [63:0] a);
    return {a[31:0], ~a[63:32]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner got %b exp 0", owner); end
    checks++; if ({if_req_ready, lsu_req_ready, mem_req_valid, if_resp_valid, lsu_resp_valid} !== 5'b0)
      begin errors++; $display("FAIL reset_strobes got %b exp 00000", {if_req_ready, lsu_req_ready, mem_req_valid, if_resp_valid, lsu_resp_valid}); end
    checks++; if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0)
      begin errors++; $display("FAIL reset_mem_regs got %h/%b/%h/%h exp 0", mem_addr, mem_wen, mem_wdata, mem_wmask); end
  endtask

  task automatic test_if_single();
    tick(); if_req_valid = 1'b1; if_addr = 64'h8000_0000; mem_req_ready = 1'b1; #1;
    checks++; if (if_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL if1_ready got if=%b lsu=%b exp 1/0", if_req_ready, lsu_req_ready); end
    tick(); if_req_valid = 1'b0; #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_0000 || mem_wen !== 1'b0 || owner !== 1'b0)
      begin errors++; $display("FAIL if1_memreq got v=%b a=%h w=%b o=%b", mem_req_valid, mem_addr, mem_wen, owner); end
    tick(); mem_resp_valid = 1'b1; mem_rdata = 64'h0010_0073; #1;
    checks++; if (if_resp_valid !== 1'b1 || if_rdata !== 64'h0010_0073 || lsu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0)
      begin errors++; $display("FAIL if1_resp got v=%b d=%h lsuv=%b mreq=%b", if_resp_valid, if_rdata, lsu_resp_valid, mem_req_valid); end
    tick(); mem_resp_valid = 1'b0; #1;
    checks++; if (busy !== 1'b0 || if_resp_valid !== 1'b0) begin errors++; $display("FAIL if1_idle got busy=%b resp=%b exp 0/0", busy, if_resp_valid); end
  endtask

  task automatic test_contention();
    tick(); if_req_valid = 1'b1; if_addr = 64'h8000_0100;
    lsu_req_valid = 1'b1; lsu_addr = 64'h8000_1000; lsu_wen = 1'b0; mem_req_ready = 1'b1; #1;
    checks++; if (lsu_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin errors++; $display("FAIL cont_grant got lsu=%b if=%b exp 1/0", lsu_req_ready, if_req_ready); end
    tick(); lsu_req_valid = 1'b0; #1;
    checks++; if (owner !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 64'h8000_1000 || if_req_ready !== 1'b0)
      begin errors++; $display("FAIL cont_lsu_req got o=%b w=%b a=%h ifr=%b", owner, mem_wen, mem_addr, if_req_ready); end
    tick(); mem_resp_valid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444; #1;
    checks++; if (lsu_resp_valid !== 1'b1 || lsu_rdata !== 64'h1111_2222_3333_4444 || if_resp_valid !== 1'b0)
      begin errors++; $display("FAIL cont_lsu_resp got v=%b d=%h ifv=%b", lsu_resp_valid, lsu_rdata, if_resp_valid); end
    tick(); mem_resp_valid = 1'b0; #1;
    checks++; if (if_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL cont_if_grant got if=%b lsu=%b exp 1/0", if_req_ready, lsu_req_ready); end
    tick(); if_req_valid = 1'b0; #1;
    checks++; if (owner !== 1'b0 || mem_addr !== 64'h8000_0100) begin errors++; $display("FAIL cont_if_req got o=%b a=%h", owner, mem_addr); end
    tick(); mem_resp_valid = 1'b1; #1;
    checks++; if (if_resp_valid !== 1'b1 || lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL cont_if_resp got if=%b lsu=%b exp 1/0", if_resp_valid, lsu_resp_valid); end
    tick(); mem_resp_valid = 1'b0;
  endtask

  task automatic test_store_stall();
    lsu_req_valid = 1'b1; lsu_addr = 64'h8000_2000; lsu_wen = 1'b1;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F; mem_req_ready = 1'b0; #1;
    checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL st_accept got %b exp 1", lsu_req_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      // Requester fields change after acceptance; the latched copy must not.
      lsu_req_valid = 1'b0; lsu_addr = {$urandom, $urandom}; lsu_wen = 1'b0;
      lsu_wdata = '0; lsu_wmask = 8'hFF; mem_req_ready = (i == 3); #1;
      checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h8000_2000 || mem_wen !== 1'b1 ||
                    mem_wdata !== 64'hDEAD_BEEF || mem_wmask !== 8'h0F || if_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0)
        begin errors++; $display("FAIL st_hold[%0d] got v=%b a=%h w=%b d=%h m=%h", i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask); end
    end
    tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = {$urandom, $urandom}; #1;
    checks++; if (lsu_resp_valid !== 1'b1 || if_resp_valid !== 1'b0 || mem_req_valid !== 1'b0)
      begin errors++; $display("FAIL st_ack got lsu=%b if=%b mreq=%b exp 1/0/0", lsu_resp_valid, if_resp_valid, mem_req_valid); end
    tick(); mem_resp_valid = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL st_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_starvation();
    bit exp_lsu;
    tick(); if_req_valid = 1'b1; if_addr = 64'h8000_0400; lsu_req_valid = 1'b1;
    lsu_addr = 64'h8000_3000; lsu_wen = 1'b0; mem_req_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_lsu = ((k % (MAX_WAIT + 1)) != MAX_WAIT);
      #1;
      checks++; if (lsu_req_ready !== exp_lsu || if_req_ready !== !exp_lsu)
        begin errors++; $display("FAIL starve_grant[%0d] got lsu=%b if=%b exp lsu=%b", k, lsu_req_ready, if_req_ready, exp_lsu); end
      tick(); tick(); mem_resp_valid = 1'b1; #1;
      checks++; if (lsu_resp_valid !== exp_lsu || if_resp_valid !== !exp_lsu)
        begin errors++; $display("FAIL starve_resp[%0d] got lsu=%b if=%b exp lsu=%b", k, lsu_resp_valid, if_resp_valid, exp_lsu); end
      tick(); mem_resp_valid = 1'b0;
      if (k == 9) begin if_req_valid = 1'b0; lsu_req_valid = 1'b0; end
    end
  endtask

  task automatic test_reset_midflight();
    tick(); if_req_valid = 1'b1; if_addr = 64'h8000_0200; mem_req_ready = 1'b1;
    tick(); if_req_valid = 1'b0;
    tick(); rst = 1'b1; mem_req_ready = 1'b0; #1;
    checks++; if (if_resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_resp_in_rst got %b exp 0", if_resp_valid); end
    tick(); rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h1234; #1;
    checks++; if ({busy, if_resp_valid, lsu_resp_valid, mem_req_valid, if_req_ready, lsu_req_ready, owner} !== 7'b0)
      begin errors++; $display("FAIL rstmid_outs got %b exp 0000000", {busy, if_resp_valid, lsu_resp_valid, mem_req_valid, if_req_ready, lsu_req_ready, owner}); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rstmid_addr got %h exp 0", mem_addr); end
    tick(); mem_resp_valid = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int ph, nph;
    tick(); if_req_valid = 1'b1; if_addr = 64'h8000_0800; mem_req_ready = 1'b1;
    // Period of 8: accept, REQ, then 6 RESP cycles (response after 5 idle).
    for (int c = 0; c < 24; c++) begin
      ph = c % 8;
      #1;
      checks++; if (if_req_ready !== (ph == 0) || mem_req_valid !== (ph == 1) || busy !== (ph != 0) || if_resp_valid !== (ph == 7))
        begin errors++; $display("FAIL b2b[%0d] got rdy=%b mreq=%b busy=%b resp=%b", c, if_req_ready, mem_req_valid, busy, if_resp_valid); end
      if (ph == 7) begin
        checks++; if (if_rdata !== rd_of(64'h8000_0800 + 64'(8 * (c / 8))))
          begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", c, if_rdata, rd_of(64'h8000_0800 + 64'(8 * (c / 8)))); end
      end
      tick();
      nph = (c + 1) % 8;
      if (ph == 0) if_addr = if_addr + 64'd8;
      mem_resp_valid = (nph == 7);
      mem_rdata = rd_of(64'h8000_0800 + 64'(8 * ((c + 1) / 8)));
      if (c == 23) if_req_valid = 1'b0;
    end
  endtask

  // Transaction-level reference: one outstanding request, LSU preferred
  // unless MAX_WAIT contended LSU wins have piled up, and each request
  // produces exactly one memory handshake and one response to its owner.
  task automatic test_random(input int n);
    bit m_idle = 1, m_hs = 0, m_own = 0, exp_if, exp_lsu, exp_mreq, resp_now;
    bit if_acc = 0, lsu_acc = 0;
    int m_cnt = 0, dly = 0, n_txn = 0;
    logic [63:0] m_addr = '0, m_wdata = '0;
    logic m_wen = 0;
    logic [7:0] m_wmask = '0;
    rst = 1'b1; if_req_valid = 0; lsu_req_valid = 0; mem_resp_valid = 0;
    tick(); rst = 1'b0;
    for (int c = 0; c < n; c++) begin
      tick();
      if (if_acc) if_req_valid = 1'b0;
      if (lsu_acc) lsu_req_valid = 1'b0;
      if_acc = 0; lsu_acc = 0;
      if (!if_req_valid && ($urandom % 3 == 0)) begin if_req_valid = 1'b1; if_addr = {$urandom, $urandom}; end
      if (!lsu_req_valid && ($urandom % 3 == 0)) begin
        lsu_req_valid = 1'b1; lsu_addr = {$urandom, $urandom}; lsu_wen = 1'($urandom);
        lsu_wdata = {$urandom, $urandom}; lsu_wmask = 8'($urandom);
      end
      mem_req_ready = 1'($urandom);
      resp_now = m_hs && (dly == 0);
      mem_resp_valid = resp_now || (!m_hs && ($urandom % 4 == 0));
      mem_rdata = resp_now ? rd_of(m_addr) : {$urandom, $urandom};
      #1;
      exp_if   = m_idle && if_req_valid && !(lsu_req_valid && m_cnt < MAX_WAIT);
      exp_lsu  = m_idle && lsu_req_valid && !exp_if;
      exp_mreq = !m_idle && !m_hs;
      checks++; if (if_req_ready !== exp_if || lsu_req_ready !== exp_lsu)
        begin errors++; $display("FAIL rnd_ready[%0d] got if=%b lsu=%b exp %b/%b", c, if_req_ready, lsu_req_ready, exp_if, exp_lsu); end
      checks++; if (mem_req_valid !== exp_mreq || busy !== !m_idle)
        begin errors++; $display("FAIL rnd_mreq[%0d] got v=%b busy=%b exp %b/%b", c, mem_req_valid, busy, exp_mreq, !m_idle); end
      if (exp_mreq) begin
        checks++; if (mem_addr !== m_addr || mem_wen !== m_wen || mem_wdata !== m_wdata || mem_wmask !== m_wmask || owner !== m_own)
          begin errors++; $display("FAIL rnd_fields[%0d] got %h/%b/%h/%h/%b exp %h/%b/%h/%h/%b", c, mem_addr, mem_wen, mem_wdata, mem_wmask, owner, m_addr, m_wen, m_wdata, m_wmask, m_own); end
      end
      checks++; if (if_resp_valid !== (resp_now && !m_own) || lsu_resp_valid !== (resp_now && m_own))
        begin errors++; $display("FAIL rnd_resp[%0d] got if=%b lsu=%b exp own=%b now=%b", c, if_resp_valid, lsu_resp_valid, m_own, resp_now); end
      if (resp_now && !m_wen) begin
        checks++; if ((m_own ? lsu_rdata : if_rdata) !== rd_of(m_addr))
          begin errors++; $display("FAIL rnd_rdata[%0d] got %h exp %h", c, m_own ? lsu_rdata : if_rdata, rd_of(m_addr)); end
      end
      if (resp_now) begin m_idle = 1; m_hs = 0; n_txn++; end
      else if (m_hs) dly--;
      if (exp_mreq && mem_req_ready) begin m_hs = 1; dly = $urandom % 4; end
      if (exp_if) begin
        m_idle = 0; m_own = 0; m_addr = if_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
        m_cnt = 0; if_acc = 1;
      end
      if (exp_lsu) begin
        m_idle = 0; m_own = 1; m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
        if (if_req_valid && m_cnt < MAX_WAIT) m_cnt++;
        lsu_acc = 1;
      end
    end
    checks++; if (n_txn < 50) begin errors++; $display("FAIL rnd_progress got %0d txns exp >= 50", n_txn); end
  endtask

  initial begin
    test_reset();
    test_if_single();
    test_contention();
    test_store_stall();
    test_starvation();
    test_reset_midflight();
    test_back_to_back();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
